mips_multicycle_ctrl: RTL and testbench
=======================================

MIPS_MULTICYCLE_CTRL -- requirements
Module: mips_multicycle_ctrl

Interface
REQ-001 The block SHALL have parameter `CNT_W`, default 32: width of the retired-instruction counter.
REQ-002 The block SHALL have port `clk`: input, 1 bit, sole clock, rising edge.
REQ-003 The block SHALL have port `rst_n`: input, 1 bit, synchronous active-low reset.
REQ-004 The block SHALL have inputs `op` (6 bits) and `funct` (6 bits): instruction-register fields, valid from DECODE onward.
REQ-005 The block SHALL have input `zero` (1 bit): ALU zero flag.
REQ-006 The block SHALL have input `mem_ready` (1 bit): memory completes the current access this cycle.
REQ-007 The block SHALL have 1-bit outputs `pc_write`, `pc_write_cond`, `iord` (0=PC addr, 1=ALUOut addr), `mem_read`, `mem_write`, `ir_write`, `reg_write`.
REQ-008 The block SHALL have outputs `reg_dst` (2 bits: 00 rt, 01 rd, 10 $31) and `mem_to_reg` (2 bits: 00 ALUOut, 01 MDR, 10 PC, 11 shift result).
REQ-009 The block SHALL have outputs `alu_src_a` (1 bit: 0 PC, 1 rs) and `alu_src_b` (2 bits: 00 rt, 01 const 4, 10 ext imm, 11 ext imm<<2).
REQ-010 The block SHALL have output `ext_zero` (1 bit: 1 zero-extend imm, 0 sign-extend).
REQ-011 The block SHALL have output `alu_control` (4 bits: 0010 add, 0110 sub, 0000 and, 0001 or, 0111 slt, 1110 sll).
REQ-012 The block SHALL have output `pc_source` (2 bits: 00 ALU result, 01 ALUOut, 10 jump target, 11 rs).
REQ-013 The block SHALL have outputs `state` (4 bits, current state), `illegal_op` (1-cycle pulse) and `retired` (CNT_W bits).

Function
REQ-014 The block SHALL implement a Moore FSM with states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, REXEC, RWB, IEXEC, IWB, BEQ, JMP, JAL, JR.
REQ-015 In FETCH the block SHALL drive mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_control=0010; when mem_ready=1 it SHALL also pulse ir_write=1, pc_write=1, pc_source=00 and go to DECODE, otherwise it SHALL hold.
REQ-016 In DECODE the block SHALL drive alu_src_a=0, alu_src_b=11, alu_control=0010 (branch target precompute).
REQ-017 From DECODE the block SHALL dispatch: op 35/43 -> MEMADR; op 0 with funct 8 -> JR; op 0 with other funct -> REXEC; op 8/13 -> IEXEC; op 4 -> BEQ; op 2 -> JMP; op 3 -> JAL.
REQ-018 On an illegal dispatch (any other op, or op 0 with funct outside {0,8,32,34,36,37,42}) the block SHALL pulse illegal_op, return to FETCH and not increment retired.
REQ-019 MEMADR SHALL drive alu_src_a=1, alu_src_b=10, add; then go to MEMRD (op 35) or MEMWR (op 43).
REQ-020 MEMRD and MEMWR SHALL assert iord=1 with mem_read or mem_write respectively and hold until mem_ready=1; MEMRD then goes to MEMWB, MEMWR goes to FETCH.
REQ-021 MEMWB SHALL drive reg_write=1, reg_dst=00, mem_to_reg=01.
REQ-022 REXEC SHALL drive alu_src_a=1, alu_src_b=00, alu_control per funct; RWB SHALL drive reg_write=1, reg_dst=01, mem_to_reg=11 for sll and 00 otherwise.
REQ-023 IEXEC SHALL drive alu_src_a=1, alu_src_b=10, with add/ext_zero=0 for addi and or/ext_zero=1 for ori; IWB SHALL drive reg_write=1, reg_dst=00, mem_to_reg=00.
REQ-024 BEQ SHALL drive alu_src_a=1, alu_src_b=00, sub, pc_write_cond=1, pc_source=01.
REQ-025 JMP SHALL drive pc_write=1, pc_source=10; JAL SHALL additionally drive reg_write=1, reg_dst=10, mem_to_reg=10; JR SHALL drive pc_write=1, pc_source=11.
REQ-026 MEMWB, MEMWR-complete, RWB, IWB, BEQ, JMP, JAL and JR SHALL each increment retired by 1 and return to FETCH; retired SHALL wrap modulo 2^CNT_W.
REQ-027 Every output not named for a state SHALL be 0 in that state (no X outputs).
REQ-028 Latency in cycles with zero wait SHALL be: lw 5, sw 4, R-type/addi/ori 4, beq/j/jal/jr 3; each mem_ready=0 cycle SHALL add one cycle.

Reset
REQ-029 While rst_n=0 at a clk edge, the block SHALL enter FETCH, clear retired to 0, clear illegal_op to 0, and abort any in-flight access, including MEMWR.
REQ-030 All outputs SHALL be combinational from state, except retired and illegal_op, which SHALL be registered.

Structure
REQ-031 State encodings, opcode/funct constants, alu_control codes and the mux-select codes SHALL reside in a shared package, mips_pkg.
REQ-032 funct-to-alu_control decode SHALL be one sub-module, alu_decode, reused by REXEC.

Verification
REQ-033 lw (op 35) with mem_ready low 2 cycles in MEMRD -> 7 cycles FETCH..MEMWB, reg_write=1 with mem_to_reg=01 in the final cycle, retired 0->1.
REQ-034 R-type sll (op 0, funct 0) -> REXEC alu_control=1110, RWB mem_to_reg=11, reg_dst=01, 4 cycles.
REQ-035 beq with zero=1 -> BEQ cycle pc_write_cond=1, pc_source=01, alu_control=0110; back in FETCH next cycle.
REQ-036 jal (op 3) -> JAL cycle pc_write=1, pc_source=10, reg_dst=10, mem_to_reg=10, reg_write=1; then jr (op 0, funct 8) -> pc_source=11, reg_write=0.
REQ-037 op 0x3F -> illegal_op=1 for exactly one cycle, state=FETCH next, retired unchanged.
REQ-038 rst_n=0 during MEMWR with mem_ready=0 -> next cycle state=FETCH, mem_write=0, retired=0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS controller: FSM states, opcode and
// funct fields, ALU operation codes and datapath mux selects.
package mips_pkg;

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        REXEC  = 4'd6,
        RWB    = 4'd7,
        IEXEC  = 4'd8,
        IWB    = 4'd9,
        BEQ    = 4'd10,
        JMP    = 4'd11,
        JAL    = 4'd12,
        JR     = 4'd13
    } state_t;

    // Opcodes
    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_JAL   = 6'd3;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_ORI   = 6'd13;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    // R-type funct codes
    localparam logic [5:0] FN_SLL = 6'd0;
    localparam logic [5:0] FN_JR  = 6'd8;
    localparam logic [5:0] FN_ADD = 6'd32;
    localparam logic [5:0] FN_SUB = 6'd34;
    localparam logic [5:0] FN_AND = 6'd36;
    localparam logic [5:0] FN_OR  = 6'd37;
    localparam logic [5:0] FN_SLT = 6'd42;

    // ALU operation codes
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_SLL = 4'b1110;

    // Register-file destination select
    localparam logic [1:0] REGDST_RT = 2'b00;
    localparam logic [1:0] REGDST_RD = 2'b01;
    localparam logic [1:0] REGDST_RA = 2'b10;

    // Register-file write-data select
    localparam logic [1:0] M2R_ALUOUT = 2'b00;
    localparam logic [1:0] M2R_MDR    = 2'b01;
    localparam logic [1:0] M2R_PC     = 2'b10;
    localparam logic [1:0] M2R_SHIFT  = 2'b11;

    // ALU operand selects
    localparam logic       SRCA_PC    = 1'b0;
    localparam logic       SRCA_RS    = 1'b1;
    localparam logic [1:0] SRCB_RT    = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    // Next-PC select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_RS     = 2'b11;

    // States in which an instruction completes unconditionally
    function automatic logic is_final_state(input state_t s);
        return (s == MEMWB) || (s == RWB) || (s == IWB) || (s == BEQ) ||
               (s == JMP) || (s == JAL) || (s == JR);
    endfunction

endpackage

// File: rtl/alu_decode.sv
// R-type funct to ALU operation decode; also flags whether the funct is an
// ALU operation this controller implements.
module alu_decode
    import mips_pkg::*;
(
    input  logic [5:0] funct,
    output logic [3:0] alu_ctl,
    output logic       known
);

    // Map funct to an ALU operation; unknown functs fall back to add
    always_comb begin
        alu_ctl = ALU_ADD;
        known   = 1'b1;
        case (funct)
            FN_SLL:  alu_ctl = ALU_SLL;
            FN_ADD:  alu_ctl = ALU_ADD;
            FN_SUB:  alu_ctl = ALU_SUB;
            FN_AND:  alu_ctl = ALU_AND;
            FN_OR:   alu_ctl = ALU_OR;
            FN_SLT:  alu_ctl = ALU_SLT;
            default: known   = 1'b0;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control unit: Moore FSM sequencing fetch, decode and the
// per-class execute/writeback steps, with a retired-instruction counter and
// an illegal-instruction pulse.
module mips_multicycle_ctrl
    import mips_pkg::*;
#(
    parameter int CNT_W = 32
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       op,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             reg_write,
    output logic [1:0]       reg_dst,
    output logic [1:0]       mem_to_reg,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic             ext_zero,
    output logic [3:0]       alu_control,
    output logic [1:0]       pc_source,
    output logic [3:0]       state,
    output logic             illegal_op,
    output logic [CNT_W-1:0] retired
);

    state_t     cur;
    state_t     decode_next;
    logic [3:0] rtype_ctl;
    logic       rtype_known;
    logic       retire;

    // The branch decision is made in the datapath by gating pc_write_cond
    // with the ALU zero flag, so the controller never consumes zero itself.
    logic unused_zero;
    assign unused_zero = zero;

    alu_decode u_alu_decode (
        .funct   (funct),
        .alu_ctl (rtype_ctl),
        .known   (rtype_known)
    );

    // Decode-time dispatch; FETCH as a result means the instruction is illegal
    function automatic state_t dispatch(input logic [5:0] o, input logic [5:0] f,
                                        input logic r_known);
        state_t s;
        s = FETCH;
        case (o)
            OP_LW, OP_SW:    s = MEMADR;
            OP_RTYPE: begin
                if (f == FN_JR)
                    s = JR;
                else if (r_known)
                    s = REXEC;
            end
            OP_ADDI, OP_ORI: s = IEXEC;
            OP_BEQ:          s = BEQ;
            OP_J:            s = JMP;
            OP_JAL:          s = JAL;
            default:         s = FETCH;
        endcase
        return s;
    endfunction

    assign decode_next = dispatch(op, funct, rtype_known);
    assign retire      = is_final_state(cur) || ((cur == MEMWR) && mem_ready);
    assign state       = cur;

    // State sequencing, retired counter and illegal-op pulse
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur        <= FETCH;
            retired    <= '0;
            illegal_op <= 1'b0;
        end else begin
            illegal_op <= (cur == DECODE) && (decode_next == FETCH);
            if (retire)
                retired <= retired + CNT_W'(1);
            case (cur)
                FETCH:   if (mem_ready) cur <= DECODE;
                DECODE:  cur <= decode_next;
                MEMADR:  cur <= (op == OP_SW) ? MEMWR : MEMRD;
                MEMRD:   if (mem_ready) cur <= MEMWB;
                MEMWR:   if (mem_ready) cur <= FETCH;
                REXEC:   cur <= RWB;
                IEXEC:   cur <= IWB;
                default: cur <= FETCH;
            endcase
        end
    end

    // Datapath control decode from the current state
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_write     = 1'b0;
        reg_dst       = REGDST_RT;
        mem_to_reg    = M2R_ALUOUT;
        alu_src_a     = SRCA_PC;
        alu_src_b     = SRCB_RT;
        ext_zero      = 1'b0;
        alu_control   = ALU_AND;
        pc_source     = PCSRC_ALU;
        case (cur)
            FETCH: begin
                mem_read    = 1'b1;
                alu_src_b   = SRCB_FOUR;
                alu_control = ALU_ADD;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                end
            end
            DECODE: begin
                alu_src_b   = SRCB_IMMSH;
                alu_control = ALU_ADD;
            end
            MEMADR: begin
                alu_src_a   = SRCA_RS;
                alu_src_b   = SRCB_IMM;
                alu_control = ALU_ADD;
            end
            MEMRD: begin
                iord     = 1'b1;
                mem_read = 1'b1;
            end
            MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = M2R_MDR;
            end
            MEMWR: begin
                iord      = 1'b1;
                mem_write = 1'b1;
            end
            REXEC: begin
                alu_src_a   = SRCA_RS;
                alu_control = rtype_ctl;
            end
            RWB: begin
                reg_write  = 1'b1;
                reg_dst    = REGDST_RD;
                mem_to_reg = (funct == FN_SLL) ? M2R_SHIFT : M2R_ALUOUT;
            end
            IEXEC: begin
                alu_src_a = SRCA_RS;
                alu_src_b = SRCB_IMM;
                if (op == OP_ORI) begin
                    alu_control = ALU_OR;
                    ext_zero    = 1'b1;
                end else begin
                    alu_control = ALU_ADD;
                end
            end
            IWB: begin
                reg_write = 1'b1;
            end
            BEQ: begin
                alu_src_a     = SRCA_RS;
                alu_control   = ALU_SUB;
                pc_write_cond = 1'b1;
                pc_source     = PCSRC_ALUOUT;
            end
            JMP: begin
                pc_write  = 1'b1;
                pc_source = PCSRC_JUMP;
            end
            JAL: begin
                pc_write   = 1'b1;
                pc_source  = PCSRC_JUMP;
                reg_write  = 1'b1;
                reg_dst    = REGDST_RA;
                mem_to_reg = M2R_PC;
            end
            JR: begin
                pc_write  = 1'b1;
                pc_source = PCSRC_RS;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for the multicycle MIPS controller. Each step pushes the
// expected control word and retired count, then compares them against the
// DUT mid-cycle.
module tb_mips_multicycle_ctrl;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [5:0]    op;
    logic [5:0]    funct;
    logic          zero;
    logic          mem_ready;
    logic          pc_write, pc_write_cond, iord, mem_read, mem_write;
    logic          ir_write, reg_write, alu_src_a, ext_zero, illegal_op;
    logic [1:0]    reg_dst, mem_to_reg, alu_src_b, pc_source;
    logic [3:0]    alu_control, state;
    logic [CW-1:0] retired;

    typedef struct {
        logic [25:0]   vec;
        logic [CW-1:0] ret;
    } exp_t;

    exp_t          sb[$];
    int            vectors = 0;
    int            miscompares = 0;
    logic [CW-1:0] ret_exp = '0;

    localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2,
                           S_MEMRD = 4'd3, S_MEMWB = 4'd4, S_MEMWR = 4'd5,
                           S_REXEC = 4'd6, S_RWB = 4'd7, S_IEXEC = 4'd8,
                           S_IWB = 4'd9, S_BEQ = 4'd10, S_JMP = 4'd11,
                           S_JAL = 4'd12, S_JR = 4'd13;

    mips_multicycle_ctrl #(.CNT_W(CW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .op            (op),
        .funct         (funct),
        .zero          (zero),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .iord          (iord),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .reg_write     (reg_write),
        .reg_dst       (reg_dst),
        .mem_to_reg    (mem_to_reg),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .ext_zero      (ext_zero),
        .alu_control   (alu_control),
        .pc_source     (pc_source),
        .state         (state),
        .illegal_op    (illegal_op),
        .retired       (retired)
    );

    always #5 clk = ~clk;

    // Reference control word for a state, built from the control tables
    function automatic logic [25:0] exp_vec(input logic [3:0] st, input logic [5:0] o,
                                            input logic [5:0] f, input logic mr,
                                            input logic ill);
        logic pw, pwc, io, mrd, mwr, irw, rw, sa, ez;
        logic [1:0] rd, m2r, sbs, pcs;
        logic [3:0] alu;
        pw = 0; pwc = 0; io = 0; mrd = 0; mwr = 0; irw = 0; rw = 0; sa = 0; ez = 0;
        rd = 2'b00; m2r = 2'b00; sbs = 2'b00; pcs = 2'b00; alu = 4'b0000;
        case (st)
            S_FETCH:  begin mrd = 1; sbs = 2'b01; alu = 4'b0010; if (mr) begin irw = 1; pw = 1; end end
            S_DECODE: begin sbs = 2'b11; alu = 4'b0010; end
            S_MEMADR: begin sa = 1; sbs = 2'b10; alu = 4'b0010; end
            S_MEMRD:  begin io = 1; mrd = 1; end
            S_MEMWB:  begin rw = 1; m2r = 2'b01; end
            S_MEMWR:  begin io = 1; mwr = 1; end
            S_REXEC: begin
                sa = 1;
                case (f)
                    6'd0:    alu = 4'b1110;
                    6'd32:   alu = 4'b0010;
                    6'd34:   alu = 4'b0110;
                    6'd36:   alu = 4'b0000;
                    6'd37:   alu = 4'b0001;
                    6'd42:   alu = 4'b0111;
                    default: alu = 4'bxxxx;
                endcase
            end
            S_RWB:    begin rw = 1; rd = 2'b01; m2r = (f == 6'd0) ? 2'b11 : 2'b00; end
            S_IEXEC: begin
                sa = 1; sbs = 2'b10;
                if (o == 6'd13) begin alu = 4'b0001; ez = 1; end
                else alu = 4'b0010;
            end
            S_IWB:    begin rw = 1; end
            S_BEQ:    begin sa = 1; alu = 4'b0110; pwc = 1; pcs = 2'b01; end
            S_JMP:    begin pw = 1; pcs = 2'b10; end
            S_JAL:    begin pw = 1; pcs = 2'b10; rw = 1; rd = 2'b10; m2r = 2'b10; end
            S_JR:     begin pw = 1; pcs = 2'b11; end
            default:  ;
        endcase
        return {st, pw, pwc, io, mrd, mwr, irw, rw, rd, m2r, sa, sbs, ez, alu, pcs, ill};
    endfunction

    // One clock cycle: drive mem_ready, queue expectation, check, advance
    task automatic step(input string tag, input logic [3:0] st, input logic mr,
                        input logic ill);
        exp_t        e;
        logic [25:0] obs;
        mem_ready = mr;
        sb.push_back('{vec: exp_vec(st, op, funct, mr, ill), ret: ret_exp});
        #1;
        e = sb.pop_front();
        obs = {state, pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
               reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, ext_zero,
               alu_control, pc_source, illegal_op};
        vectors++;
        assert (obs === e.vec) else begin
            miscompares++;
            $error("FAIL %s ctrl observed=%h expected=%h", tag, obs, e.vec);
        end
        vectors++;
        assert (retired === e.ret) else begin
            miscompares++;
            $error("FAIL %s retired observed=%0d expected=%0d", tag, retired, e.ret);
        end
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; op = 6'd0; funct = 6'd32; zero = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        step("reset", S_FETCH, 1'b0, 1'b0);
        rst_n = 1'b1;

        // lw with a fetch stall and two memory wait cycles
        op = 6'd35;
        step("lw_fetch_hold", S_FETCH, 1'b0, 1'b0);
        step("lw_fetch", S_FETCH, 1'b1, 1'b0);
        step("lw_decode", S_DECODE, 1'b0, 1'b0);
        step("lw_memadr", S_MEMADR, 1'b0, 1'b0);
        step("lw_memrd_w1", S_MEMRD, 1'b0, 1'b0);
        step("lw_memrd_w2", S_MEMRD, 1'b0, 1'b0);
        step("lw_memrd", S_MEMRD, 1'b1, 1'b0);
        step("lw_memwb", S_MEMWB, 1'b0, 1'b0);
        ret_exp = ret_exp + 1'b1;

        // sw, no wait
        op = 6'd43;
        step("sw_fetch", S_FETCH, 1'b1, 1'b0);
        step("sw_decode", S_DECODE, 1'b0, 1'b0);
        step("sw_memadr", S_MEMADR, 1'b0, 1'b0);
        step("sw_memwr", S_MEMWR, 1'b1, 1'b0);
        ret_exp = ret_exp + 1'b1;

        // R-type sll and sub
        op = 6'd0; funct = 6'd0;
        step("sll_fetch", S_FETCH, 1'b1, 1'b0);
        step("sll_decode", S_DECODE, 1'b0, 1'b0);
        step("sll_rexec", S_REXEC, 1'b0, 1'b0);
        step("sll_rwb", S_RWB, 1'b0, 1'b0);
        ret_exp = ret_exp + 1'b1;
        funct = 6'd34;
        step("sub_fetch", S_FETCH, 1'b1, 1'b0);
        step("sub_decode", S_DECODE, 1'b0, 1'b0);
        step("sub_rexec", S_REXEC, 1'b0, 1'b0);
        step("sub_rwb", S_RWB, 1'b0, 1'b0);
        ret_exp = ret_exp + 1'b1;

        // ori and addi
        op = 6'd13;
        step("ori_fetch", S_FETCH, 1'b1, 1'b0);
        step("ori_decode", S_DECODE, 1'b0, 1'b0);
        step("ori_iexec", S_IEXEC, 1'b0, 1'b0);
        step("ori_iwb", S_IWB, 1'b0, 1'b0);
        ret_exp = ret_exp + 1'b1;
        op = 6'd8;
        step("addi_fetch", S_FETCH, 1'b1, 1'b0);
        step("addi_decode", S_DECODE, 1'b0, 1'b0);
        step("addi_iexec", S_IEXEC, 1'b0, 1'b0);
        step("addi_iwb", S_IWB, 1'b0, 1'b0);
        ret_exp = ret_exp + 1'b1;

        // beq taken
        op = 6'd4; zero = 1'b1;
        step("beq_fetch", S_FETCH, 1'b1, 1'b0);
        step("beq_decode", S_DECODE, 1'b0, 1'b0);
        step("beq_exec", S_BEQ, 1'b0, 1'b0);
        ret_exp = ret_exp + 1'b1;
        zero = 1'b0;

        // jal then jr
        op = 6'd3;
        step("jal_fetch", S_FETCH, 1'b1, 1'b0);
        step("jal_decode", S_DECODE, 1'b0, 1'b0);
        step("jal_exec", S_JAL, 1'b0, 1'b0);
        ret_exp = ret_exp + 1'b1;
        op = 6'd0; funct = 6'd8;
        step("jr_fetch", S_FETCH, 1'b1, 1'b0);
        step("jr_decode", S_DECODE, 1'b0, 1'b0);
        step("jr_exec", S_JR, 1'b0, 1'b0);
        ret_exp = ret_exp + 1'b1;

        // illegal opcode: one-cycle pulse, retired unchanged
        op = 6'h3F;
        step("ill_op_fetch", S_FETCH, 1'b1, 1'b0);
        step("ill_op_decode", S_DECODE, 1'b0, 1'b0);
        step("ill_op_pulse", S_FETCH, 1'b0, 1'b1);
        step("ill_op_clear", S_FETCH, 1'b0, 1'b0);

        // illegal R-type funct
        op = 6'd0; funct = 6'd1;
        step("ill_fn_fetch", S_FETCH, 1'b1, 1'b0);
        step("ill_fn_decode", S_DECODE, 1'b0, 1'b0);
        step("ill_fn_pulse", S_FETCH, 1'b0, 1'b1);

        // j repeated across the counter wrap (9 + 10 = 19 -> 3)
        op = 6'd2;
        for (int i = 0; i < 10; i++) begin
            step("j_fetch", S_FETCH, 1'b1, 1'b0);
            step("j_decode", S_DECODE, 1'b0, 1'b0);
            step("j_exec", S_JMP, 1'b0, 1'b0);
            ret_exp = ret_exp + 1'b1;
        end
        step("wrap_check", S_FETCH, 1'b0, 1'b0);

        // reset while a store waits on memory
        op = 6'd43;
        step("rst_sw_fetch", S_FETCH, 1'b1, 1'b0);
        step("rst_sw_decode", S_DECODE, 1'b0, 1'b0);
        step("rst_sw_memadr", S_MEMADR, 1'b0, 1'b0);
        step("rst_sw_wait", S_MEMWR, 1'b0, 1'b0);
        rst_n = 1'b0;
        step("rst_sw_abort", S_MEMWR, 1'b0, 1'b0);
        ret_exp = '0;
        rst_n = 1'b1;
        step("rst_after", S_FETCH, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
